// File: rtl/costas_loop_filter.sv
// Costas phase detector (BPSK/QPSK) feeding a saturating PI loop filter
// with a hysteretic lock indicator; output drives the NCO feedback port.
module costas_loop_filter #(
    parameter int DATA_WIDTH  = 12,
    parameter int ACC_WIDTH   = 24,
    parameter int OUT_WIDTH   = 16,
    parameter int LOCK_THRESH = 64,
    parameter int LOCK_COUNT  = 16
) (
    input  logic                  clk_32M768,
    input  logic                  rst_n_32M768,
    input  logic                  enable,
    input  logic                  mode,
    input  logic [3:0]            KP_SHIFT,
    input  logic [3:0]            KI_SHIFT,
    input  logic [DATA_WIDTH-1:0] i_tdata,
    input  logic [DATA_WIDTH-1:0] q_tdata,
    input  logic                  iq_tvalid,
    output logic [OUT_WIDTH-1:0]  feedback_tdata,
    output logic                  feedback_tvalid,
    output logic                  locked
);

    localparam int EW = DATA_WIDTH + 2;
    localparam int SH = ACC_WIDTH - EW;
    localparam int CW = $clog2(LOCK_COUNT + 1);

    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic [CW-1:0] CNT_MAX  = CW'(LOCK_COUNT);
    localparam logic [CW-1:0] CNT_STEP = CW'(4);
    localparam logic [EW-1:0] THRESH   = EW'(LOCK_THRESH);

    function automatic logic signed [ACC_WIDTH-1:0] sat(
        input logic signed [ACC_WIDTH:0] x
    );
        if (x[ACC_WIDTH] != x[ACC_WIDTH-1])
            return x[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        return x[ACC_WIDTH-1:0];
    endfunction

    // Stage 1: phase detector, two guard bits make -(-2^(DW-1)) exact
    logic signed [EW-1:0] i_ext;
    logic signed [EW-1:0] q_ext;
    logic signed [EW-1:0] pd_a;
    logic signed [EW-1:0] pd_b;
    logic signed [EW-1:0] err_d;

    assign i_ext = {{2{i_tdata[DATA_WIDTH-1]}}, i_tdata};
    assign q_ext = {{2{q_tdata[DATA_WIDTH-1]}}, q_tdata};
    assign pd_a  = i_tdata[DATA_WIDTH-1] ? -q_ext : q_ext;
    assign pd_b  = q_tdata[DATA_WIDTH-1] ? -i_ext : i_ext;
    assign err_d = mode ? (pd_a - pd_b) : pd_a;

    logic signed [EW-1:0]        err_q;
    logic                        err_valid;
    logic signed [ACC_WIDTH-1:0] integ;
    logic [CW-1:0]               cnt;

    // Stage 2: PI filter on the error scaled to the accumulator MSBs
    logic signed [ACC_WIDTH-1:0] s_val;
    logic signed [ACC_WIDTH-1:0] prop;
    logic signed [ACC_WIDTH-1:0] inc;
    logic signed [ACC_WIDTH-1:0] integ_new;
    logic signed [ACC_WIDTH-1:0] sum;
    logic signed [ACC_WIDTH:0]   integ_ext;
    logic signed [ACC_WIDTH:0]   sum_ext;

    assign s_val     = {{SH{err_q[EW-1]}}, err_q} <<< SH;
    assign prop      = s_val >>> KP_SHIFT;
    assign inc       = s_val >>> KI_SHIFT;
    assign integ_ext = {integ[ACC_WIDTH-1], integ} + {inc[ACC_WIDTH-1], inc};
    assign integ_new = sat(integ_ext);
    assign sum_ext   = {integ_new[ACC_WIDTH-1], integ_new}
                     + {prop[ACC_WIDTH-1], prop};
    assign sum       = sat(sum_ext);

    logic unused_sum_lsb;
    assign unused_sum_lsb = ^sum[ACC_WIDTH-OUT_WIDTH-1:0];

    // Lock detector: fast decay (4) versus slow build (1) gives hysteresis
    logic [EW-1:0] err_mag;
    logic [CW-1:0] cnt_next;
    logic          locked_next;

    assign err_mag = err_q[EW-1] ? EW'(-err_q) : EW'(err_q);

    always_comb begin
        cnt_next    = cnt;
        locked_next = locked;
        if (err_mag < THRESH) begin
            if (cnt != CNT_MAX)
                cnt_next = cnt + 1'b1;
        end else begin
            if (cnt < CNT_STEP)
                cnt_next = '0;
            else
                cnt_next = cnt - CNT_STEP;
        end
        if (cnt_next == CNT_MAX)
            locked_next = 1'b1;
        else if (cnt_next == '0)
            locked_next = 1'b0;
    end

    always_ff @(posedge clk_32M768) begin
        if (!rst_n_32M768) begin
            err_q           <= '0;
            err_valid       <= 1'b0;
            integ           <= '0;
            cnt             <= '0;
            feedback_tdata  <= '0;
            feedback_tvalid <= 1'b0;
            locked          <= 1'b0;
        end else if (enable) begin
            err_valid       <= iq_tvalid;
            feedback_tvalid <= err_valid;
            if (iq_tvalid)
                err_q <= err_d;
            if (err_valid) begin
                integ          <= integ_new;
                feedback_tdata <= sum[ACC_WIDTH-1 -: OUT_WIDTH];
                cnt            <= cnt_next;
                locked         <= locked_next;
            end
        end
    end

endmodule

// File: tb/tb_costas_loop_filter.sv
// Directed-vector bench for costas_loop_filter with hand-computed results.
module tb_costas_loop_filter;

    logic        clk_32M768 = 1'b0;
    logic        rst_n_32M768 = 1'b0;
    logic        enable = 1'b0;
    logic        mode = 1'b0;
    logic [3:0]  KP_SHIFT = 4'd4;
    logic [3:0]  KI_SHIFT = 4'd8;
    logic [11:0] i_tdata = '0;
    logic [11:0] q_tdata = '0;
    logic        iq_tvalid = 1'b0;
    logic [15:0] feedback_tdata;
    logic        feedback_tvalid;
    logic        locked;

    int n_tests = 0;
    int n_fail = 0;

    costas_loop_filter dut (
        .clk_32M768     (clk_32M768),
        .rst_n_32M768   (rst_n_32M768),
        .enable         (enable),
        .mode           (mode),
        .KP_SHIFT       (KP_SHIFT),
        .KI_SHIFT       (KI_SHIFT),
        .i_tdata        (i_tdata),
        .q_tdata        (q_tdata),
        .iq_tvalid      (iq_tvalid),
        .feedback_tdata (feedback_tdata),
        .feedback_tvalid(feedback_tvalid),
        .locked         (locked)
    );

    always #5 clk_32M768 = ~clk_32M768;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int fb();
        return int'($signed(feedback_tdata));
    endfunction

    // One disabled edge followed by one enabled edge; outputs read 1 ns later
    task automatic step(input logic v, input int i, input int q);
        enable = 1'b0;
        iq_tvalid = 1'b0;
        @(posedge clk_32M768);
        #1;
        i_tdata = 12'(i);
        q_tdata = 12'(q);
        iq_tvalid = v;
        enable = 1'b1;
        @(posedge clk_32M768);
        #1;
        enable = 1'b0;
        iq_tvalid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n_32M768 = 1'b0;
        iq_tvalid = 1'b1;
        i_tdata = 12'd1000;
        q_tdata = 12'd200;
        repeat (4) begin
            enable = ~enable;
            @(posedge clk_32M768);
            #1;
        end
        rst_n_32M768 = 1'b1;
        enable = 1'b0;
        iq_tvalid = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_data", fb(), 0);
        chk("rst_valid", int'(feedback_tvalid), 0);
        chk("rst_locked", int'(locked), 0);

        // BPSK PI arithmetic: err=200, KP=4, KI=8
        mode = 1'b0;
        KP_SHIFT = 4'd4;
        KI_SHIFT = 4'd8;
        step(1'b1, 1000, 200);
        chk("bpsk_lat_valid", int'(feedback_tvalid), 0);
        step(1'b1, 1000, 200);
        chk("bpsk_o1", fb(), 53);
        chk("bpsk_o1_valid", int'(feedback_tvalid), 1);
        step(1'b1, 1000, 200);
        chk("bpsk_o2", fb(), 56);
        step(1'b0, 0, 0);
        chk("bpsk_o3", fb(), 59);
        chk("bpsk_o3_valid", int'(feedback_tvalid), 1);
        step(1'b0, 0, 0);
        chk("bpsk_idle_valid", int'(feedback_tvalid), 0);
        chk("bpsk_idle_hold", fb(), 59);

        // QPSK: I=-500, Q=300 gives err=+200
        do_reset();
        mode = 1'b1;
        step(1'b1, -500, 300);
        step(1'b1, -500, 300);
        chk("qpsk_o1", fb(), 53);
        step(1'b1, -500, 300);
        chk("qpsk_o2", fb(), 56);
        step(1'b0, 0, 0);
        chk("qpsk_o3", fb(), 59);

        // Negation edge: I=-1, Q=-2048 gives err=+2048
        do_reset();
        mode = 1'b0;
        step(1'b1, -1, -2048);
        step(1'b0, 0, 0);
        chk("neg_edge", fb(), 544);

        // Positive saturation, KP=KI=0, err=2047
        do_reset();
        KP_SHIFT = 4'd0;
        KI_SHIFT = 4'd0;
        step(1'b1, 2047, 2047);
        step(1'b1, 2047, 2047);
        chk("satp_o1", fb(), 16376);
        step(1'b1, 2047, 2047);
        chk("satp_o2", fb(), 24564);
        step(1'b1, 2047, 2047);
        chk("satp_o3", fb(), 32752);
        step(1'b1, 2047, 2047);
        chk("satp_o4", fb(), 32767);
        step(1'b0, 0, 0);
        chk("satp_o5", fb(), 32767);

        // Negative saturation, err=-2048
        do_reset();
        step(1'b1, 2047, -2048);
        step(1'b1, 2047, -2048);
        chk("satn_o1", fb(), -16384);
        step(1'b1, 2047, -2048);
        chk("satn_o2", fb(), -24576);
        step(1'b1, 2047, -2048);
        chk("satn_o3", fb(), -32768);
        step(1'b0, 0, 0);
        chk("satn_o4", fb(), -32768);

        // Lock hysteresis: 16 small errors then large errors
        do_reset();
        KP_SHIFT = 4'd4;
        KI_SHIFT = 4'd8;
        for (int k = 1; k <= 16; k++) begin
            step(1'b1, 1000, 10);
            if (k == 16)
                chk("lock_pre", int'(locked), 0);
        end
        step(1'b1, 1000, 500);
        chk("lock_rise", int'(locked), 1);
        step(1'b1, 1000, 500);
        step(1'b1, 1000, 500);
        step(1'b1, 1000, 500);
        chk("lock_hold", int'(locked), 1);
        step(1'b0, 0, 0);
        chk("lock_fall", int'(locked), 0);

        // Valid pulses only on disabled cycles are ignored
        do_reset();
        for (int k = 0; k < 3; k++) begin
            enable = 1'b0;
            iq_tvalid = 1'b1;
            i_tdata = 12'd1000;
            q_tdata = 12'd200;
            @(posedge clk_32M768);
            #1;
            iq_tvalid = 1'b0;
            enable = 1'b1;
            @(posedge clk_32M768);
            #1;
            enable = 1'b0;
        end
        chk("gate_valid", int'(feedback_tvalid), 0);
        chk("gate_data", fb(), 0);

        // Mid-run reset restarts the integrator
        mode = 1'b0;
        for (int k = 0; k < 5; k++)
            step(1'b1, 1000, 200);
        rst_n_32M768 = 1'b0;
        enable = 1'b1;
        iq_tvalid = 1'b1;
        @(posedge clk_32M768);
        #1;
        chk("midrst_data", fb(), 0);
        chk("midrst_valid", int'(feedback_tvalid), 0);
        rst_n_32M768 = 1'b1;
        enable = 1'b0;
        iq_tvalid = 1'b0;
        step(1'b1, 1000, 200);
        chk("midrst_lat", int'(feedback_tvalid), 0);
        step(1'b1, 1000, 200);
        chk("midrst_o1", fb(), 53);
        step(1'b0, 0, 0);
        chk("midrst_o2", fb(), 56);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
